// File: rtl/rf_wb_pkg.sv
// Shared entry type and constants for the register-file writeback queue.
// Combinational helpers only; no state, no latency, no backpressure.
// Bypass feature of the top level is selected by macro RF_WB_BYPASS_EN.
package rf_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  fp;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_entry_t;

  // Integer r0 is hardwired to zero; the FP file has no such register.
  function automatic logic is_zero_reg(input logic fp, input logic [REG_ADDR_W-1:0] addr);
    return !fp && (addr == ZERO_REG);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular writeback queue exposing every slot and its valid bit.
// Entry visible at the head one cycle after push; push ignored when full, pop ignored when empty.
// Caller owns backpressure via o_full; no pass-through of a simultaneous pop.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  rf_entry_t                i_push_dat,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
  output rf_entry_t [DEPTH-1:0]    o_entries,
  output logic [DEPTH-1:0]         o_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  rf_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DEPTH-1:0]      r_vld;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Payload storage needs no reset; r_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_vld[r_wr_ptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count   = r_count;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_entries = r_mem;
  assign o_vld     = r_vld;

endmodule

// File: rtl/rf_writeback.sv
// Arbitrates load/ALU results (load wins) into a queue drained through the RF write port; RF_WB_BYPASS_EN adds read bypass.
// Accepted entry reaches WrEn/WrAddr/WData one cycle after acceptance; the head holds while rf_stall=1.
// Readies drop while the queue is full (even if it drains that cycle) and during reset.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic                   alu_fp,
  input  logic [REG_ADDR_W-1:0]  alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic                   mem_fp,
  input  logic [REG_ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   rf_stall,
  output logic                   WrEn,
  output logic                   ftpt_write,
  output logic [REG_ADDR_W-1:0]  WrAddr,
  output logic [DATA_W-1:0]      WData,
  output logic [$clog2(DEPTH):0] count
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic                   ftpt_read,
  input  logic [REG_ADDR_W-1:0]  Read1,
  input  logic [REG_ADDR_W-1:0]  Read2,
  output logic                   byp1_hit,
  output logic                   byp2_hit,
  output logic [DATA_W-1:0]      byp1_data,
  output logic [DATA_W-1:0]      byp2_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic                  w_full;
  logic                  w_empty;
  logic [PTR_W-1:0]      w_rd_ptr;
  rf_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_vld;
  rf_entry_t             w_in;
  rf_entry_t             w_head;
  logic                  w_mem_xfer;
  logic                  w_alu_xfer;
  logic                  w_push;

  assign mem_ready  = !rst && !w_full;
  assign alu_ready  = !rst && !w_full && !mem_valid;
  assign w_mem_xfer = mem_valid && mem_ready;
  assign w_alu_xfer = alu_valid && alu_ready;

  always_comb begin
    w_in = '0;
    if (w_mem_xfer) begin
      w_in = '{fp: mem_fp, addr: mem_addr, data: mem_data};
    end else if (w_alu_xfer) begin
      w_in = '{fp: alu_fp, addr: alu_addr, data: alu_data};
    end
  end

  // r0 writes complete the handshake but never occupy a slot.
  assign w_push = (w_mem_xfer || w_alu_xfer) && !is_zero_reg(w_in.fp, w_in.addr);

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_in),
    .i_pop      (WrEn),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (count),
    .o_rd_ptr   (w_rd_ptr),
    .o_entries  (w_entries),
    .o_vld      (w_vld)
  );

  assign w_head     = w_entries[w_rd_ptr];
  assign WrEn       = !rst && !w_empty && !rf_stall;
  assign ftpt_write = WrEn && w_head.fp;
  assign WrAddr     = WrEn ? w_head.addr : '0;
  assign WData      = WrEn ? w_head.data : '0;

`ifdef RF_WB_BYPASS_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to newest so the last match left standing is the newest.
  always_comb begin
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PTR_W'(k);
      if (w_vld[w_idx] && !is_zero_reg(ftpt_read, Read1) &&
          w_entries[w_idx].fp == ftpt_read && w_entries[w_idx].addr == Read1) begin
        byp1_hit  = 1'b1;
        byp1_data = w_entries[w_idx].data;
      end
      if (w_vld[w_idx] && !is_zero_reg(ftpt_read, Read2) &&
          w_entries[w_idx].fp == ftpt_read && w_entries[w_idx].addr == Read2) begin
        byp2_hit  = 1'b1;
        byp2_data = w_entries[w_idx].data;
      end
    end
  end
`else
  logic w_unused_vld;
  assign w_unused_vld = ^w_vld;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed vector table, wrap/bypass sequences, then random traffic against a queue model.
module tb_rf_writeback;
  import rf_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          alu_valid, alu_ready, alu_fp;
  logic [4:0]    alu_addr;
  logic [31:0]   alu_data;
  logic          mem_valid, mem_ready, mem_fp;
  logic [4:0]    mem_addr;
  logic [31:0]   mem_data;
  logic          rf_stall;
  logic          WrEn, ftpt_write;
  logic [4:0]    WrAddr;
  logic [31:0]   WData;
  logic [CW-1:0] count;
`ifdef RF_WB_BYPASS_EN
  logic          ftpt_read;
  logic [4:0]    Read1, Read2;
  logic          byp1_hit, byp2_hit;
  logic [31:0]   byp1_data, byp2_data;
`endif

  int checks   = 0;
  int failures = 0;
  int rc       = 0;
  rf_entry_t mq[$];

  rf_writeback #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_fp     (alu_fp),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_fp     (mem_fp),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .rf_stall   (rf_stall),
    .WrEn       (WrEn),
    .ftpt_write (ftpt_write),
    .WrAddr     (WrAddr),
    .WData      (WData),
    .count      (count)
`ifdef RF_WB_BYPASS_EN
    ,
    .ftpt_read  (ftpt_read),
    .Read1      (Read1),
    .Read2      (Read2),
    .byp1_hit   (byp1_hit),
    .byp2_hit   (byp2_hit),
    .byp1_data  (byp1_data),
    .byp2_data  (byp2_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, av, afp;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ar, mr, we, fw;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(int r, int st, int av, int afp, int aa, int ad, int mv, int ma, int md,
                              int ar, int mr, int we, int fw, int wa, int wd, int cnt);
    vec_t v;
    v.rst = 1'(r);   v.stall = 1'(st); v.av = 1'(av); v.afp = 1'(afp);
    v.aa  = 5'(aa);  v.ad = 32'(ad);   v.mv = 1'(mv); v.ma = 5'(ma); v.md = 32'(md);
    v.ar  = 1'(ar);  v.mr = 1'(mr);    v.we = 1'(we); v.fw = 1'(fw);
    v.wa  = 5'(wa);  v.wd = 32'(wd);   v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One clock of random traffic: compare against the queue model, then advance the model.
  task automatic run_cycle();
    logic        e_mr, e_ar, e_we;
    rf_entry_t   hd;
`ifdef RF_WB_BYPASS_EN
    logic        h1, h2;
    logic [31:0] d1, d2;
`endif
    @(negedge clk);
    rc++;
    e_mr = !rst && (mq.size() < DEPTH);
    e_ar = e_mr && !mem_valid;
    e_we = !rst && (mq.size() != 0) && !rf_stall;
    hd   = e_we ? mq[0] : '0;
    chk1($sformatf("r%0d mem_ready", rc), mem_ready, e_mr);
    chk1($sformatf("r%0d alu_ready", rc), alu_ready, e_ar);
    chk1($sformatf("r%0d WrEn", rc), WrEn, e_we);
    chk1($sformatf("r%0d ftpt_write", rc), ftpt_write, hd.fp);
    chk($sformatf("r%0d WrAddr", rc), 32'(WrAddr), 32'(hd.addr));
    chk($sformatf("r%0d WData", rc), WData, hd.data);
    chk($sformatf("r%0d count", rc), 32'(count), 32'(mq.size()));
`ifdef RF_WB_BYPASS_EN
    h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].fp == ftpt_read && mq[i].addr == Read1 && !(ftpt_read == 1'b0 && Read1 == 5'd0)) begin
        h1 = 1'b1; d1 = mq[i].data;
      end
      if (mq[i].fp == ftpt_read && mq[i].addr == Read2 && !(ftpt_read == 1'b0 && Read2 == 5'd0)) begin
        h2 = 1'b1; d2 = mq[i].data;
      end
    end
    chk1($sformatf("r%0d byp1_hit", rc), byp1_hit, h1);
    chk1($sformatf("r%0d byp2_hit", rc), byp2_hit, h2);
    chk($sformatf("r%0d byp1_data", rc), byp1_data, d1);
    chk($sformatf("r%0d byp2_data", rc), byp2_data, d2);
`endif
    if (rst) begin
      mq.delete();
    end else begin
      if (e_we) void'(mq.pop_front());
      if (mem_valid && e_mr) begin
        if (mem_fp || mem_addr != 5'd0) mq.push_back('{fp: mem_fp, addr: mem_addr, data: mem_data});
      end else if (alu_valid && e_ar) begin
        if (alu_fp || alu_addr != 5'd0) mq.push_back('{fp: alu_fp, addr: alu_addr, data: alu_data});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[$];
    rst = 1'b1; rf_stall = 1'b0;
    alu_valid = 1'b1; alu_fp = 1'b0; alu_addr = 5'd3; alu_data = 32'h2ae42;
    mem_valid = 1'b0; mem_fp = 1'b0; mem_addr = '0; mem_data = '0;
`ifdef RF_WB_BYPASS_EN
    ftpt_read = 1'b0; Read1 = '0; Read2 = '0;
`endif
    @(posedge clk);
    #1;

    //           rst st av fp aa     ad         mv ma md          ar mr we fw wa  wd         cnt
    vt.push_back(mk(1, 0, 1, 0,  3, 'h2ae42,   0, 0, 0,          0, 0, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 0, 1, 0,  3, 'h2ae42,   0, 0, 0,          1, 1, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 1, 0,  3, 'h2ae42,   1));
    vt.push_back(mk(0, 0, 1, 0,  1, 'h32137,   1, 2, 'h8b004e,   0, 1, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 0, 1, 0,  1, 'h32137,   0, 0, 0,          1, 1, 1, 0,  2, 'h8b004e,  1));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 1, 0,  1, 'h32137,   1));
    vt.push_back(mk(0, 1, 1, 0, 10, 'ha0,      0, 0, 0,          1, 1, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 1, 1, 0, 11, 'ha1,      0, 0, 0,          1, 1, 0, 0,  0, 0,         1));
    vt.push_back(mk(0, 1, 1, 0, 12, 'ha2,      0, 0, 0,          1, 1, 0, 0,  0, 0,         2));
    vt.push_back(mk(0, 1, 1, 0, 13, 'ha3,      0, 0, 0,          1, 1, 0, 0,  0, 0,         3));
    vt.push_back(mk(0, 1, 1, 0, 14, 'ha4,      1, 15, 'hb5,      0, 0, 0, 0,  0, 0,         4));
    vt.push_back(mk(0, 0, 1, 0, 14, 'ha4,      0, 0, 0,          0, 0, 1, 0, 10, 'ha0,      4));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 1, 0, 11, 'ha1,      3));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 1, 0, 12, 'ha2,      2));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 1, 0, 13, 'ha3,      1));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 0, 1, 0,  0, 'hfde546,  0, 0, 0,          1, 1, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 0, 1, 1,  0, 'h5a5a,    0, 0, 0,          1, 1, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 1, 1,  0, 'h5a5a,    1));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 1, 0, 0,  0, 0,         1, 7, 'h77,       0, 1, 0, 0,  0, 0,         0));
    vt.push_back(mk(0, 1, 0, 0,  0, 0,         1, 8, 'h88,       0, 1, 0, 0,  0, 0,         1));
    vt.push_back(mk(1, 0, 0, 0,  0, 0,         0, 0, 0,          0, 0, 0, 0,  0, 0,         2));
    vt.push_back(mk(0, 0, 0, 0,  0, 0,         0, 0, 0,          1, 1, 0, 0,  0, 0,         0));

    foreach (vt[i]) begin
      rst = vt[i].rst; rf_stall = vt[i].stall;
      alu_valid = vt[i].av; alu_fp = vt[i].afp; alu_addr = vt[i].aa; alu_data = vt[i].ad;
      mem_valid = vt[i].mv; mem_fp = 1'b0; mem_addr = vt[i].ma; mem_data = vt[i].md;
      @(negedge clk);
      chk1($sformatf("v%0d alu_ready", i), alu_ready, vt[i].ar);
      chk1($sformatf("v%0d mem_ready", i), mem_ready, vt[i].mr);
      chk1($sformatf("v%0d WrEn", i), WrEn, vt[i].we);
      chk1($sformatf("v%0d ftpt_write", i), ftpt_write, vt[i].fw);
      chk($sformatf("v%0d WrAddr", i), 32'(WrAddr), 32'(vt[i].wa));
      chk($sformatf("v%0d WData", i), WData, vt[i].wd);
      chk($sformatf("v%0d count", i), 32'(count), 32'(vt[i].cnt));
      @(posedge clk);
      #1;
    end

    // Back-to-back pushes with the drain running: occupancy stays at 1 across pointer wrap.
    rst = 1'b0; rf_stall = 1'b0; mem_valid = 1'b0; alu_fp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      alu_valid = (k < 10);
      alu_addr  = 5'(k % 7 + 1);
      alu_data  = 32'(32'h1000 + k);
      @(negedge clk);
      if (k == 0 || k == 11) begin
        chk($sformatf("wrap%0d count", k), 32'(count), 32'd0);
        chk1($sformatf("wrap%0d WrEn", k), WrEn, 1'b0);
      end else begin
        chk($sformatf("wrap%0d count", k), 32'(count), 32'd1);
        chk1($sformatf("wrap%0d WrEn", k), WrEn, 1'b1);
        chk($sformatf("wrap%0d WrAddr", k), 32'(WrAddr), 32'((k - 1) % 7 + 1));
        chk($sformatf("wrap%0d WData", k), WData, 32'(32'h1000 + k - 1));
      end
      @(posedge clk);
      #1;
    end

`ifdef RF_WB_BYPASS_EN
    rf_stall = 1'b1; alu_valid = 1'b1; alu_fp = 1'b0; alu_addr = 5'd5; alu_data = 32'h11;
    @(posedge clk); #1;
    alu_data = 32'h22;
    @(posedge clk); #1;
    alu_valid = 1'b0; ftpt_read = 1'b0; Read1 = 5'd5; Read2 = 5'd5;
    @(negedge clk);
    chk1("byp r5 int hit1", byp1_hit, 1'b1);
    chk("byp r5 int data1", byp1_data, 32'h22);
    chk1("byp r5 int hit2", byp2_hit, 1'b1);
    chk("byp r5 int data2", byp2_data, 32'h22);
    @(posedge clk); #1;
    ftpt_read = 1'b1;
    @(negedge clk);
    chk1("byp r5 fp hit1", byp1_hit, 1'b0);
    chk1("byp r5 fp hit2", byp2_hit, 1'b0);
    @(posedge clk); #1;
    ftpt_read = 1'b0; Read1 = 5'd0; Read2 = 5'd6;
    @(negedge clk);
    chk1("byp r0 hit1", byp1_hit, 1'b0);
    chk1("byp r6 hit2", byp2_hit, 1'b0);
    @(posedge clk); #1;
    rf_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`endif

    mq.delete();
    rst = 1'b1; rf_stall = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    run_cycle();
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      rf_stall  = ($urandom_range(0, 2) == 0);
      alu_valid = 1'($urandom_range(0, 1));
      alu_fp    = 1'($urandom_range(0, 1));
      alu_addr  = 5'($urandom_range(0, 7));
      alu_data  = $urandom();
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_fp    = 1'($urandom_range(0, 1));
      mem_addr  = 5'($urandom_range(0, 7));
      mem_data  = $urandom();
`ifdef RF_WB_BYPASS_EN
      ftpt_read = 1'($urandom_range(0, 1));
      Read1     = 5'($urandom_range(0, 7));
      Read2     = 5'($urandom_range(0, 7));
`endif
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
